// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package display_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    SHOW1  = 3'd1,
    BLANK1 = 3'd2,
    SHOW4  = 3'd3,
    BLANK4 = 3'd4
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba patterns, index 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7seg_decoder.sv
// Hex nibble to active-low 7-segment pattern, purely combinational.
module hex7seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[code];

endmodule

// File: rtl/display_scan_ctrl.sv
// Two-digit scan driver: alternates digit 1 / digit 4 with a blanking gap
// between them; segment data is latched only on entry to each SHOW state.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DIV_MAX    = 50000,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned SHOW_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       onoff,
  input  logic [3:0] val1,
  input  logic [3:0] val4,
  output logic       sel,
  output logic       digit1_out,
  output logic       digit4_out,
  output logic [6:0] seg_n
);

  localparam int unsigned TICK_W = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;

  state_t              state;
  state_t              state_next;
  logic [DIV_W-1:0]    presc;
  logic [TICK_W-1:0]   tick_cnt;
  logic [3:0]          code;
  logic [3:0]          code_next;
  logic                tick;
  logic                last_tick;
  logic [6:0]          seg_dec;

  assign tick      = (presc == DIV_W'(DIV_MAX - 1));
  assign last_tick = tick && (tick_cnt == TICK_W'(SHOW_TICKS - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= OFF;
    end else begin
      state <= state_next;
    end
  end

  // Next state and code latch selection; onoff = 0 overrides every transition
  always_comb begin
    state_next = state;
    code_next  = code;
    unique case (state)
      OFF:    if (onoff)     state_next = SHOW1;
      SHOW1:  if (last_tick) state_next = BLANK1;
      BLANK1: if (tick)      state_next = SHOW4;
      SHOW4:  if (last_tick) state_next = BLANK4;
      BLANK4: if (tick)      state_next = SHOW1;
      default:               state_next = OFF;
    endcase
    if (!onoff) begin
      state_next = OFF;
    end
    if (state_next != state) begin
      if (state_next == SHOW1) code_next = val1;
      if (state_next == SHOW4) code_next = val4;
    end
  end

  // Prescaler, tick counter and latched code; counters restart on any state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      tick_cnt <= '0;
      code     <= '0;
    end else begin
      code <= code_next;
      if (state_next != state) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        presc    <= '0;
        tick_cnt <= tick_cnt + TICK_W'(1);
      end else begin
        presc    <= presc + DIV_W'(1);
      end
    end
  end

  hex7seg_decoder u_dec (
    .code  (code),
    .seg_n (seg_dec)
  );

  // Output decode from state and latched code only
  always_comb begin
    sel        = 1'b0;
    digit1_out = 1'b1;
    digit4_out = 1'b1;
    seg_n      = SEG_BLANK;
    unique case (state)
      SHOW1: begin
        digit1_out = 1'b0;
        seg_n      = seg_dec;
      end
      SHOW4: begin
        sel        = 1'b1;
        digit4_out = 1'b0;
        seg_n      = seg_dec;
      end
      BLANK4:  sel = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed plus randomized bench for display_scan_ctrl against a frame-position model.
module tb_display_scan_ctrl;

  localparam int unsigned DIV        = 4;
  localparam int unsigned TICKS      = 2;
  localparam int          SHOW_LEN   = DIV * TICKS;
  localparam int          BLANK_LEN  = DIV;
  localparam int          FRAME      = 2 * (SHOW_LEN + BLANK_LEN);

  logic       clk = 1'b0;
  logic       reset;
  logic       onoff;
  logic [3:0] val1;
  logic [3:0] val4;
  logic       sel;
  logic       digit1_out;
  logic       digit4_out;
  logic [6:0] seg_n;

  int compared = 0;
  int mismatched = 0;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: display on/off plus position within the frame and the two latched values
  bit         m_on;
  int         m_pos;
  logic [3:0] m_c1;
  logic [3:0] m_c4;

  display_scan_ctrl #(
    .DIV_MAX    (DIV),
    .DIV_W      (3),
    .SHOW_TICKS (TICKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .onoff      (onoff),
    .val1       (val1),
    .val4       (val4),
    .sel        (sel),
    .digit1_out (digit1_out),
    .digit4_out (digit4_out),
    .seg_n      (seg_n)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    if (reset || !onoff) begin
      m_on = 1'b0;
    end else if (!m_on) begin
      m_on  = 1'b1;
      m_pos = 0;
      m_c1  = val1;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
      if (m_pos == 0) m_c1 = val1;
      if (m_pos == SHOW_LEN + BLANK_LEN) m_c4 = val4;
    end
  endtask

  task automatic check(string tag);
    logic       e_sel = 1'b0;
    logic       e_d1 = 1'b1;
    logic       e_d4 = 1'b1;
    logic [6:0] e_seg = 7'h7F;
    if (m_on) begin
      if (m_pos < SHOW_LEN) begin
        e_d1 = 1'b0; e_seg = tbl[m_c1];
      end else if (m_pos < SHOW_LEN + BLANK_LEN) begin
        e_sel = 1'b0;
      end else if (m_pos < 2 * SHOW_LEN + BLANK_LEN) begin
        e_sel = 1'b1; e_d4 = 1'b0; e_seg = tbl[m_c4];
      end else begin
        e_sel = 1'b1;
      end
    end
    compared++;
    assert (sel === e_sel) else begin
      mismatched++;
      $error("FAIL %s sel observed=%0b expected=%0b pos=%0d", tag, sel, e_sel, m_pos);
    end
    compared++;
    assert (digit1_out === e_d1) else begin
      mismatched++;
      $error("FAIL %s digit1_out observed=%0b expected=%0b pos=%0d", tag, digit1_out, e_d1, m_pos);
    end
    compared++;
    assert (digit4_out === e_d4) else begin
      mismatched++;
      $error("FAIL %s digit4_out observed=%0b expected=%0b pos=%0d", tag, digit4_out, e_d4, m_pos);
    end
    compared++;
    assert (seg_n === e_seg) else begin
      mismatched++;
      $error("FAIL %s seg_n observed=%h expected=%h pos=%0d", tag, seg_n, e_seg, m_pos);
    end
    compared++;
    assert (!(digit1_out === 1'b0 && digit4_out === 1'b0)) else begin
      mismatched++;
      $error("FAIL %s overlap observed=%0b%0b expected=not 00", tag, digit1_out, digit4_out);
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic steps(int n, string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic run_until_pos(int p, string tag);
    int n = 0;
    while (!(m_on && m_pos == p) && n < 2 * FRAME) begin
      step(tag);
      n++;
    end
    if (!(m_on && m_pos == p)) begin
      compared++;
      mismatched++;
      $error("FAIL %s timeout observed_pos=%0d expected_pos=%0d", tag, m_pos, p);
    end
  endtask

  initial begin
    reset = 1'b1;
    onoff = 1'b0;
    val1  = 4'h0;
    val4  = 4'h0;
    m_on  = 1'b0;
    m_pos = 0;
    m_c1  = 4'h0;
    m_c4  = 4'h0;
    #1;
    check("reset_state");
    steps(3, "reset_hold");

    // Release with onoff=1: first edge enters SHOW1
    onoff = 1'b1;
    val1  = 4'h3;
    val4  = 4'hA;
    reset = 1'b0;
    steps(2 * FRAME, "frame_3A");

    // Mid-SHOW1 change of val1 must not tear the current digit
    run_until_pos(1, "tear_align");
    val1 = 4'h8;
    steps(FRAME + SHOW_LEN, "no_tear");

    // Drop onoff during SHOW4, then re-enable
    run_until_pos(SHOW_LEN + BLANK_LEN + 2, "off_align");
    onoff = 1'b0;
    steps(3, "onoff_low");
    onoff = 1'b1;
    steps(FRAME + 2, "onoff_reenter");

    // Sweep val1 through every code
    for (int v = 0; v < 16; v++) begin
      run_until_pos(FRAME - 1, "sweep_align");
      val1 = 4'(v);
      steps(SHOW_LEN, "sweep");
    end

    // Async reset mid-cycle while running: outputs clear without a clock
    run_until_pos(SHOW_LEN + BLANK_LEN + 3, "rst_align");
    #2;
    reset = 1'b1;
    #1;
    m_on = 1'b0;
    check("async_reset");
    steps(2, "reset_held");
    #1;
    reset = 1'b0;
    steps(FRAME, "after_reset");

    // Randomized inputs and occasional onoff drops
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) val1 = 4'($urandom);
      if ($urandom_range(0, 5) == 0) val4 = 4'($urandom);
      if (onoff && $urandom_range(0, 60) == 0) onoff = 1'b0;
      else if (!onoff && $urandom_range(0, 3) == 0) onoff = 1'b1;
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
